// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing defaults, colours and sync polarity constants
package vga_timing_pkg;

    localparam int CNT_W = 11;

    // 640x480@60 with a 25 MHz pixel clock
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_H_ACT  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;
    localparam int DEF_V_ACT  = 480;
    localparam int DEF_V_FP   = 10;

    localparam bit POL_LOW  = 1'b0;
    localparam bit POL_HIGH = 1'b1;

    localparam logic [23:0] BLACK    = 24'h000000;
    localparam logic [23:0] RED      = 24'hFF0000;
    localparam logic [23:0] GREEN    = 24'h00FF00;
    localparam logic [23:0] BLUE     = 24'h0000FF;
    localparam logic [23:0] YELLOW   = 24'hFFFF00;
    localparam logic [23:0] SKY_BLUE = 24'h00FFFF;
    localparam logic [23:0] PURPLE   = 24'hFF00FF;
    localparam logic [23:0] GRAY     = 24'h808080;
    localparam logic [23:0] WHITE    = 24'hFFFFFF;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } vga_sync_t;

endpackage

// File: rtl/vga_axis_cnt.sv
// rtl/vga_axis_cnt.sv - wrap-around raster axis counter with enable and wrap strobe
module vga_axis_cnt
    import vga_timing_pkg::*;
#(
    parameter int TOT = 800
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             wrap_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/vga_ctrl.sv
// rtl/vga_ctrl.sv - VGA raster timing with two-stage realignment of sync, enable and colour
module vga_ctrl
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int H_ACT  = DEF_H_ACT,
    parameter int H_FP   = DEF_H_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP,
    parameter int V_ACT  = DEF_V_ACT,
    parameter int V_FP   = DEF_V_FP,
    parameter bit HS_POL = POL_LOW,
    parameter bit VS_POL = POL_LOW
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] h_addr,
    output logic [CNT_W-1:0] v_addr,
    output logic             addr_vld,
    input  logic [23:0]      data_dis,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             vga_de,
    output logic [23:0]      vga_rgb,
    output logic             frame_end
);

    localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
    localparam logic [CNT_W-1:0] H_ACT_S = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_ACT_E = CNT_W'(H_SYNC + H_BP + H_ACT);
    localparam logic [CNT_W-1:0] V_ACT_S = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_ACT_E = CNT_W'(V_SYNC + V_BP + V_ACT);
    localparam vga_sync_t SYNC_IDLE = '{hs: !HS_POL, vs: !VS_POL, de: 1'b0};

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic             active;
    vga_sync_t        s1_d;
    vga_sync_t        s1_q;
    vga_sync_t        s2_q;
    logic [23:0]      rgb_q;
    logic             frame_end_q;

    vga_axis_cnt #(.TOT(H_TOT)) u_h_cnt (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (1'b1),
        .cnt_o  (h_cnt),
        .wrap_o (h_wrap)
    );

    // v_wrap only fires on the line wrap, so it marks the last pixel of the frame
    vga_axis_cnt #(.TOT(V_TOT)) u_v_cnt (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (h_wrap),
        .cnt_o  (v_cnt),
        .wrap_o (v_wrap)
    );

    always_comb begin
        active = (h_cnt >= H_ACT_S) && (h_cnt < H_ACT_E) &&
                 (v_cnt >= V_ACT_S) && (v_cnt < V_ACT_E);
        s1_d.hs = (h_cnt < CNT_W'(H_SYNC)) ? HS_POL : !HS_POL;
        s1_d.vs = (v_cnt < CNT_W'(V_SYNC)) ? VS_POL : !VS_POL;
        s1_d.de = active;
    end

    assign addr_vld = active;
    assign h_addr   = active ? h_cnt - H_ACT_S : '0;
    assign v_addr   = active ? v_cnt - V_ACT_S : '0;

    // Stage 1 lines up with the source's registered colour; stage 2 drives the pins together
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= SYNC_IDLE;
            s2_q        <= SYNC_IDLE;
            rgb_q       <= BLACK;
            frame_end_q <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s1_q;
            rgb_q       <= s1_q.de ? data_dis : BLACK;
            frame_end_q <= v_wrap;
        end
    end

    assign vga_hs    = s2_q.hs;
    assign vga_vs    = s2_q.vs;
    assign vga_de    = s2_q.de;
    assign vga_rgb   = rgb_q;
    assign frame_end = frame_end_q;

endmodule

// File: tb/tb_vga_ctrl.sv
// tb/tb_vga_ctrl.sv - directed bench for vga_ctrl: default 640x480 timing plus a tiny inverted-polarity mode
module tb_vga_ctrl;

    logic        clk;
    logic        rst;
    logic [23:0] data_dis;
    logic        gen_on;

    logic [10:0] h_addr, v_addr;
    logic        addr_vld, vga_hs, vga_vs, vga_de, frame_end;
    logic [23:0] vga_rgb;

    logic [10:0] p_h_addr, p_v_addr;
    logic        p_addr_vld, p_hs, p_vs, p_de, p_frame_end;
    logic [23:0] p_rgb;

    int total, bad, cyc;
    int hs_low, p_vs_cnt, p_hs_cnt, p_de_cnt, p_de_lines, fe_n, fe1, fe2;
    int hs_fall, de_rise, de_cnt;
    logic p_de_prev, hs_prev, de_prev;

    vga_ctrl u_dut (
        .clk       (clk),
        .rst       (rst),
        .h_addr    (h_addr),
        .v_addr    (v_addr),
        .addr_vld  (addr_vld),
        .data_dis  (data_dis),
        .vga_hs    (vga_hs),
        .vga_vs    (vga_vs),
        .vga_de    (vga_de),
        .vga_rgb   (vga_rgb),
        .frame_end (frame_end)
    );

    // H_TOT = 13 (active 5..10), V_TOT = 8 (active 3..6), frame = 104 cycles
    vga_ctrl #(
        .H_SYNC(3), .H_BP(2), .H_ACT(6), .H_FP(2),
        .V_SYNC(2), .V_BP(1), .V_ACT(4), .V_FP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_pol (
        .clk       (clk),
        .rst       (rst),
        .h_addr    (p_h_addr),
        .v_addr    (p_v_addr),
        .addr_vld  (p_addr_vld),
        .data_dis  (data_dis),
        .vga_hs    (p_hs),
        .vga_vs    (p_vs),
        .vga_de    (p_de),
        .vga_rgb   (p_rgb),
        .frame_end (p_frame_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] gen_colour(input logic [10:0] h, input logic [10:0] v, input logic vld);
        if (!vld)         return 24'hC0FFEE;
        else if (h == 0)  return 24'h0000FF;
        else if (h == 80) return 24'hFF0000;
        else              return {5'h0, v[7:0], h};
    endfunction

    always_ff @(posedge clk) begin
        data_dis <= gen_on ? gen_colour(h_addr, v_addr, addr_vld) : 24'hFFFFFF;
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_hs"}, 32'(vga_hs), 32'd1);
        chk({tag, "_vs"}, 32'(vga_vs), 32'd1);
        chk({tag, "_de"}, 32'(vga_de), 32'd0);
        chk({tag, "_rgb"}, 32'(vga_rgb), 32'd0);
        chk({tag, "_vld"}, 32'(addr_vld), 32'd0);
        chk({tag, "_haddr"}, 32'(h_addr), 32'd0);
        chk({tag, "_vaddr"}, 32'(v_addr), 32'd0);
        chk({tag, "_fend"}, 32'(frame_end), 32'd0);
        chk({tag, "_p_hs"}, 32'(p_hs), 32'd0);
        chk({tag, "_p_vs"}, 32'(p_vs), 32'd0);
        chk({tag, "_p_de"}, 32'(p_de), 32'd0);
        chk({tag, "_p_rgb"}, 32'(p_rgb), 32'd0);
        chk({tag, "_p_vld"}, 32'(p_addr_vld), 32'd0);
        chk({tag, "_p_addr"}, 32'({p_h_addr, p_v_addr}), 32'd0);
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        rst = 1'b1; gen_on = 1'b0;

        repeat (5) step();
        chk_reset_values("reset_hold");

        // cyc counts edges since release; outputs after edge k reflect counter position k-2
        rst = 1'b0; gen_on = 1'b1; cyc = 0;
        chk("rel0_hs", 32'(vga_hs), 32'd1);
        hs_low = 0; p_vs_cnt = 0; p_hs_cnt = 0; p_de_cnt = 0; p_de_lines = 0;
        fe_n = 0; fe1 = 0; fe2 = 0; p_de_prev = 1'b0;
        while (cyc < 801) begin
            step();
            if (cyc == 1) chk("rel1_hs", 32'(vga_hs), 32'd1);
            if (cyc == 2) begin
                chk("rel2_hs", 32'(vga_hs), 32'd0);
                chk("rel2_p_hs", 32'(p_hs), 32'd1);
            end
            if (!vga_hs) hs_low++;
            if (cyc <= 209) begin
                if (p_vs) p_vs_cnt++;
                if (p_hs) p_hs_cnt++;
                if (p_de) p_de_cnt++;
                if (p_de && !p_de_prev) p_de_lines++;
            end
            p_de_prev = p_de;
            if (p_frame_end) begin
                fe_n++;
                if (fe_n == 1) fe1 = cyc;
                if (fe_n == 2) fe2 = cyc;
            end
        end
        chk("line_hs_low", 32'(hs_low), 32'd96);
        chk("pol_vs_high_2frames", 32'(p_vs_cnt), 32'd52);
        chk("pol_hs_high_2frames", 32'(p_hs_cnt), 32'd48);
        chk("pol_de_cycles", 32'(p_de_cnt), 32'd48);
        chk("pol_de_lines", 32'(p_de_lines), 32'd8);
        chk("pol_fend_first", 32'(fe1), 32'd104);
        chk("pol_fend_period", 32'(fe2 - fe1), 32'd104);
        chk("pol_fend_count", 32'(fe_n), 32'd7);
        chk("dflt_no_fend", 32'(frame_end), 32'd0);

        while (cyc < 28000) step();
        hs_prev = vga_hs; de_prev = vga_de;
        hs_fall = 0; de_rise = 0; de_cnt = 0;
        while (cyc < 28801) begin
            step();
            if (hs_prev && !vga_hs) hs_fall = cyc;
            if (!de_prev && vga_de) de_rise = cyc;
            if (vga_de) de_cnt++;
            hs_prev = vga_hs; de_prev = vga_de;
            if (cyc == 28145) begin
                chk("pre_de", 32'(vga_de), 32'd0);
                chk("pre_rgb", 32'(vga_rgb), 32'd0);
            end
            if (cyc == 28146) begin
                chk("px0_de", 32'(vga_de), 32'd1);
                chk("px0_rgb", 32'(vga_rgb), 32'h0000FF);
            end
            if (cyc == 28151) chk("px5_rgb", 32'(vga_rgb), 32'h000005);
            if (cyc == 28224) begin
                chk("addr80_h", 32'(h_addr), 32'd80);
                chk("addr80_v", 32'(v_addr), 32'd0);
                chk("addr80_vld", 32'(addr_vld), 32'd1);
            end
            if (cyc == 28226) chk("px80_rgb", 32'(vga_rgb), 32'hFF0000);
            if (cyc == 28785) chk("px639_de", 32'(vga_de), 32'd1);
            if (cyc == 28786) begin
                chk("post_de", 32'(vga_de), 32'd0);
                chk("post_rgb", 32'(vga_rgb), 32'd0);
            end
        end
        chk("line35_hs_fall", 32'(hs_fall), 32'd28002);
        chk("line35_de_offset", 32'(de_rise - hs_fall), 32'd144);
        chk("line35_de_cnt", 32'(de_cnt), 32'd640);

        while (cyc < 28951) step();
        chk("line36_px5_rgb", 32'(vga_rgb), 32'h000805);

        while (cyc < 29200) step();
        chk("mid_de_before_rst", 32'(vga_de), 32'd1);
        rst = 1'b1;
        step();
        chk_reset_values("mid_reset");
        rst = 1'b0; cyc = 0;
        step();
        chk("mid_rel1_hs", 32'(vga_hs), 32'd1);
        chk("mid_rel1_rgb", 32'(vga_rgb), 32'd0);
        step();
        chk("mid_rel2_hs", 32'(vga_hs), 32'd0);
        chk("mid_rel2_vs", 32'(vga_vs), 32'd0);
        chk("mid_rel2_p_hs", 32'(p_hs), 32'd1);
        chk("mid_rel2_p_vs", 32'(p_vs), 32'd1);
        while (cyc < 103) step();
        chk("mid_p_fend_103", 32'(p_frame_end), 32'd0);
        step();
        chk("mid_p_fend_104", 32'(p_frame_end), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
